pwm_peripheral: RTL and testbench

Consumes the five configuration registers written over SPI (output enables, PWM-mode enables, duty cycle) and drives the 16 user output pins. Each pin is statically low, statically high, or driven by one shared PWM waveform, according to its two enable bits. The block sits directly downstream of the SPI register file. Its outputs go straight to the chip pads.

---
 rtl/pwm_pkg.sv | 7 +
 rtl/pwm_peripheral_if.sv | 10 +
 rtl/pwm_timebase.sv | 27 ++
 rtl/pwm_peripheral.sv | 49 ++++
 tb/tb_pwm_peripheral.sv | 131 +++++++++++++
 5 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants for the PWM peripheral
package pwm_pkg;
  localparam int PWM_CNT_W = 8;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int CLK_DIV_DEFAULT = 13;
  localparam int NUM_PINS = 16;
endpackage

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: configuration register bundle from the SPI register file
interface pwm_peripheral_if;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  modport master (output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle);
  modport slave (input en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle);
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: clock prescaler and shared 8-bit PWM counter
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PWM_CNT_W-1:0] pwm_cnt,
  output logic                 tick,
  output logic                 wrap
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div_cnt;
  assign tick = div_cnt == DW'(CLK_DIV - 1);
  assign wrap = tick && pwm_cnt == DUTY_FULL;
  // prescaler wraps after CLK_DIV clocks; pwm_cnt steps on each tick and overflows naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 pins low/high/PWM from SPI config; PWM_SHADOW_EN latches duty at period boundaries
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  pwm_peripheral_if.slave     regs,
  output logic [NUM_PINS-1:0] out,
  output logic                period_start
);
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_active;
  logic                 tick;
  logic                 wrap;
  logic                 pwm_hi;
  logic [NUM_PINS-1:0]  en_out;
  logic [NUM_PINS-1:0]  en_pwm;
  pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
    .clk(clk),
    .rst(rst),
    .pwm_cnt(pwm_cnt),
    .tick(tick),
    .wrap(wrap)
  );
`ifdef PWM_SHADOW_EN
  // duty only changes at the period boundary so no period is truncated
  always_ff @(posedge clk) begin
    if (rst) duty_active <= '0;
    else if (wrap) duty_active <= regs.pwm_duty_cycle;
  end
`else
  assign duty_active = regs.pwm_duty_cycle;
`endif
  assign en_out = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
  assign en_pwm = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
  assign pwm_hi = duty_active == DUTY_FULL ? 1'b1 : pwm_cnt < duty_active;
  // registered pad drive: disabled pins low, static pins high, PWM pins follow the shared waveform
  always_ff @(posedge clk) begin
    if (rst) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= en_out & (~en_pwm | {NUM_PINS{pwm_hi}});
      period_start <= tick & wrap;
    end
  end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: directed self-checking bench for pwm_peripheral (CLK_DIV 13 and 1)
module tb_pwm_peripheral;
  import pwm_pkg::*;
  localparam int DIV = 13;
  localparam int PER = 256 * DIV;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] out;
  logic [15:0] out1;
  logic        ps;
  logic        ps1;
  int          n_tests = 0;
  int          n_fail = 0;
  pwm_peripheral_if bus();
  pwm_peripheral #(.CLK_DIV(DIV)) dut (.clk(clk), .rst(rst), .regs(bus), .out(out), .period_start(ps));
  pwm_peripheral #(.CLK_DIV(1)) dut1 (.clk(clk), .rst(rst), .regs(bus), .out(out1), .period_start(ps1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic set_regs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    bus.en_reg_out_7_0  = eo[7:0];
    bus.en_reg_out_15_8 = eo[15:8];
    bus.en_reg_pwm_7_0  = ep[7:0];
    bus.en_reg_pwm_15_8 = ep[15:8];
    bus.pwm_duty_cycle  = d;
  endtask
  task automatic wait_ps(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps && n < 2 * PER + 8);
    check({tag, "_ps_seen"}, 32'(ps), 32'd1);
  endtask
  task automatic high_count(output int hi, output int mixed);
    hi = 0;
    mixed = 0;
    for (int j = 0; j < PER; j++) begin
      @(negedge clk);
      if (out == 16'hFFFF) hi++;
      else if (out != 16'h0000) mixed++;
    end
  endtask
  task automatic measure(input string tag, input logic [7:0] d, input int exp_hi);
    int n, hi, mixed;
    set_regs(16'hFFFF, 16'hFFFF, d);
    wait_ps(tag, n);
    high_count(hi, mixed);
    check({tag, "_high"}, hi, exp_hi);
    check({tag, "_aligned"}, mixed, 0);
  endtask
  initial begin
    int n, hi, mixed, bad;
    set_regs(16'($urandom), 16'($urandom), 8'($urandom));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_out", out, 0);
      check("rst_ps", 32'(ps), 0);
    end
    set_regs(16'h0000, 16'h0000, 8'h00);
    rst = 1'b0;
    check("rel_out", out, 0);
    check("rel_ps", 32'(ps), 0);
    @(negedge clk);
    check("rel1_out", out, 0);
    set_regs(16'hFFFF, 16'h0000, 8'h00);
    @(negedge clk);
    check("static_ffff", out, 32'hFFFF);
    check("static_ffff_div1", out1, 32'hFFFF);
    set_regs(16'h00F0, 16'h0000, 8'h00);
    @(negedge clk);
    check("static_00f0", out, 32'h00F0);
    set_regs(16'h0000, 16'hFFFF, 8'hFF);
    bad = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      @(negedge clk);
      if (out != 16'h0000) bad++;
    end
    check("mask", bad, 0);
    measure("duty00", 8'h00, 0);
    measure("dutyff", 8'hFF, PER);
    measure("duty80", 8'h80, 128 * DIV);
    wait_ps("period", n);
    check("period_len", n, PER);
    measure("duty40", 8'h40, 64 * DIV);
    hi = 0;
    for (int j = 0; j < PER; j++) begin
      @(negedge clk);
      if (out == 16'hFFFF) hi++;
      if (j == 32 * DIV - 1) bus.pwm_duty_cycle = 8'hC0;
    end
`ifdef PWM_SHADOW_EN
    check("mid_change_cur", hi, 64 * DIV);
`else
    check("mid_change_cur", hi, 192 * DIV);
`endif
    high_count(hi, mixed);
    check("mid_change_next", hi, 192 * DIV);
    n = 0;
    while (!ps1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("div1_ps_seen", 32'(ps1), 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps1 && n < 600);
    check("div1_period", n, 256);
    set_regs(16'hFFFF, 16'h0000, 8'h00);
    repeat (500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", out, 0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ps && n < 2 * PER);
    check("midrst_restart", n, PER);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
